adapter_4_to_1_synth: RTL and testbench
=======================================

Name: adapter_4_to_1_synth

Overview:
- Packs four DATA_WIDTH-bit lanes (r0..r3) into one N_INPUTS*DATA_WIDTH-bit bus r.
- r0 occupies the least-significant lane.
- Sits between per-lane datapath logic and wide-bus consumers.
- Registered output: one clock of latency, cleared by reset, with a valid qualifier.

Parameters:
- DATA_WIDTH, 16, width of each input lane in bits.
- N_INPUTS, 4, number of lanes. Fixed at 4 because the ports are r0..r3; any other value is a configuration error and elaboration must fail.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  qualifies r0..r3 this cycle.
- r0  input  DATA_WIDTH  lane 0.
- r1  input  DATA_WIDTH  lane 1.
- r2  input  DATA_WIDTH  lane 2.
- r3  input  DATA_WIDTH  lane 3.
- r  output  N_INPUTS*DATA_WIDTH  packed bus.
- valid_out  output  1  r holds a packed word.

Behaviour:
- Reset: while reset=1, r=0 and valid_out=0 immediately, without waiting for a clock edge. Reset has priority over everything else.
- Lane mapping, with i in 0..3: r[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i] = ri. With 16-bit lanes:
  - r[15:0] = r0
  - r[31:16] = r1
  - r[47:32] = r2
  - r[63:48] = r3
- No reordering, sign extension or arithmetic; bit-exact copy of each lane.
- Load rule: at a rising clk edge with reset=0 and valid_in=1, r <= the packed value of r0..r3 sampled at that edge, and valid_out <= 1.
- Hold rule: at a rising clk edge with reset=0 and valid_in=0, r holds its previous value and valid_out <= 0.
- Latency: exactly 1 cycle from a sampled valid_in=1 to the corresponding r and valid_out=1.
- Throughput: one word per cycle; back-to-back valid_in produces back-to-back valid_out.
- No backpressure; the consumer must accept every valid_out cycle.
- Reset asserted mid-stream: the in-flight word is discarded; r=0 and valid_out=0 until the first load after reset deasserts.
- Reset deasserting on the same edge as valid_in=1: recovery is defined as synchronous. The first edge with reset low loads normally.
- Inputs changing between edges have no effect on r.
- X on a lane propagates only to that lane's field of r.

Decomposition:
- Shared package/include holds:
  - DATA_WIDTH default (16) and N_INPUTS (4) constants.
  - A macro or function for the lane slice index DATA_WIDTH*i.
- One natural sub-module: adapter_lane_reg. It is a DATA_WIDTH-wide register with async active-high reset and load enable. Instantiate it 4 times with a generate loop, plus one 1-bit register for valid.
- A combinational packing stage feeds the register array; no other logic.

Test Plan:
- Reset: assert reset with random lanes and valid_in=1 -> r=64'h0, valid_out=0 immediately and at every edge while held.
- Ascending load: r0=16'h0123, r1=16'h4567, r2=16'h89AB, r3=16'hCDEF, valid_in=1 -> one edge later r=64'hCDEF_89AB_4567_0123, valid_out=1.
- Reversed lanes, back-to-back: next cycle r0=16'hCDEF, r1=16'h89AB, r2=16'h4567, r3=16'h0123 -> r=64'h0123_4567_89AB_CDEF, valid_out stays 1 with no bubble.
- Mixed pattern: r0=16'hAAAA, r1=16'h0AAA, r2=16'h00BB, r3=16'h0123 -> r=64'h0123_00BB_0AAA_AAAA.
- Hold: valid_in=0 while lanes change to 16'hFFFF -> r unchanged at 64'h0123_00BB_0AAA_AAAA, valid_out=0.
- Mid-stream reset: assert reset asynchronously between edges during a valid stream -> r=0 and valid_out=0 before the next edge. After release, load 16'h0123/16'h4567/16'h89AB/16'hCDEF -> r=64'hCDEF_89AB_4567_0123 one edge later.

Source files
------------

// File: rtl/adapter_4_to_1_synth_pkg.sv
// adapter_4_to_1_synth_pkg: shared lane constants and slice-index helper
package adapter_4_to_1_synth_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int N_INPUTS_DEF = 4;
  function automatic int lane_lo(input int i, input int w);
    return w * i;
  endfunction
endpackage

// File: rtl/adapter_lane_reg.sv
// adapter_lane_reg: W-bit register with async active-high reset and load enable
module adapter_lane_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;
  assign q_o = data_q;
  // clear on reset, capture d_i when enabled, otherwise hold
  always_ff @(posedge clk or posedge rst)
    if (rst) data_q <= '0;
    else if (en_i) data_q <= d_i;
endmodule

// File: rtl/adapter_4_to_1_synth.sv
// adapter_4_to_1_synth: packs four lanes into one registered wide bus with valid
module adapter_4_to_1_synth
  import adapter_4_to_1_synth_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_INPUTS = N_INPUTS_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_in,
  input  logic [DATA_WIDTH-1:0]          r0,
  input  logic [DATA_WIDTH-1:0]          r1,
  input  logic [DATA_WIDTH-1:0]          r2,
  input  logic [DATA_WIDTH-1:0]          r3,
  output logic [N_INPUTS*DATA_WIDTH-1:0] r,
  output logic                           valid_out
);
  if (N_INPUTS != 4) begin : g_bad_n_inputs
    $error("adapter_4_to_1_synth: N_INPUTS must be 4, ports are r0..r3");
  end
  logic [DATA_WIDTH-1:0] lane_d [4];
  assign lane_d = '{r0, r1, r2, r3};
  for (genvar g = 0; g < 4; g++) begin : g_lane
    adapter_lane_reg #(.W(DATA_WIDTH)) u_lane (
      .clk (clk),
      .rst (reset),
      .en_i(valid_in),
      .d_i (lane_d[g]),
      .q_o (r[lane_lo(g, DATA_WIDTH) +: DATA_WIDTH])
    );
  end
  adapter_lane_reg #(.W(1)) u_valid (
    .clk (clk),
    .rst (reset),
    .en_i(1'b1),
    .d_i (valid_in),
    .q_o (valid_out)
  );
endmodule

// File: tb/tb_adapter_4_to_1_synth.sv
// tb_adapter_4_to_1_synth: directed plus random checks against a packing model
module tb_adapter_4_to_1_synth;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [15:0] r0, r1, r2, r3;
  logic [63:0] r;
  logic        valid_out;
  int          passed = 0;
  int          total = 0;
  logic [63:0] m_r = '0;
  logic        m_v = 1'b0;

  always #5 clk = ~clk;

  adapter_4_to_1_synth dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .r0       (r0),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
    .r        (r),
    .valid_out(valid_out)
  );

  function automatic logic [63:0] pack(input logic [15:0] a, b, c, d);
    return 64'(a) | (64'(b) << 16) | (64'(c) << 32) | (64'(d) << 48);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step(input logic rs, input logic v, input logic [15:0] a, b, c, d, input string tag);
    @(negedge clk);
    reset = rs; valid_in = v; r0 = a; r1 = b; r2 = c; r3 = d;
    @(posedge clk);
    #1;
    if (rs) begin m_r = '0; m_v = 1'b0; end
    else begin
      if (v) m_r = pack(a, b, c, d);
      m_v = v;
    end
    check({tag, ".r"}, r, m_r);
    check({tag, ".valid"}, 64'(valid_out), 64'(m_v));
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  initial begin
    reset = 1'b1; valid_in = 1'b1;
    r0 = rnd16(); r1 = rnd16(); r2 = rnd16(); r3 = rnd16();
    #1;
    check("reset_imm.r", r, 64'h0);
    check("reset_imm.valid", 64'(valid_out), 64'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rnd16(), rnd16(), rnd16(), rnd16(), "reset_held");
    step(1'b0, 1'b1, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, "ascending");
    check("ascending_const", r, 64'hCDEF_89AB_4567_0123);
    step(1'b0, 1'b1, 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123, "reversed");
    check("reversed_const", r, 64'h0123_4567_89AB_CDEF);
    check("reversed_no_bubble", 64'(valid_out), 64'h1);
    step(1'b0, 1'b1, 16'hAAAA, 16'h0AAA, 16'h00BB, 16'h0123, "mixed");
    check("mixed_const", r, 64'h0123_00BB_0AAA_AAAA);
    step(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, "hold");
    check("hold_const", r, 64'h0123_00BB_0AAA_AAAA);
    step(1'b0, 1'b1, rnd16(), rnd16(), rnd16(), rnd16(), "stream");
    #2;
    reset = 1'b1;
    #1;
    check("midreset_imm.r", r, 64'h0);
    check("midreset_imm.valid", 64'(valid_out), 64'h0);
    m_r = '0; m_v = 1'b0;
    step(1'b1, 1'b1, rnd16(), rnd16(), rnd16(), rnd16(), "midreset_held");
    step(1'b0, 1'b1, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, "recover");
    check("recover_const", r, 64'hCDEF_89AB_4567_0123);
    for (int i = 0; i < 60; i++)
      step(($urandom_range(15) == 0), 1'($urandom), rnd16(), rnd16(), rnd16(), rnd16(), "random");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
